// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings, control bundle and helpers for hazard_ctrl
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_UNUSED   = 2'd3
  } hz_state_e;

  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam int          REG_ZERO       = 0;
  localparam int          REG_ADDR_W_DEF = 5;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_bubble;
    logic ex_mem_en;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NORMAL = hz_ctrl_t'(6'b110101);
  localparam hz_ctrl_t CTRL_FREEZE = hz_ctrl_t'(6'b000000);
  localparam hz_ctrl_t CTRL_LU     = hz_ctrl_t'(6'b000111);
  localparam hz_ctrl_t CTRL_BRANCH = hz_ctrl_t'(6'b111111);
  localparam hz_ctrl_t CTRL_REDIR  = hz_ctrl_t'(6'b111101);
  localparam hz_ctrl_t CTRL_RESET  = hz_ctrl_t'(6'b001010);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - hazard inputs from ID/EX/MEM and pipeline control outputs
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_branch_taken;
  logic                  mem_busy;

  logic                  pc_enable;
  logic                  if_id_enable;
  logic                  if_id_flush;
  logic                  id_ex_enable;
  logic                  id_ex_bubble;
  logic                  ex_mem_enable;
  logic                  timeout_err;
  logic [1:0]            state_o;

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_mem_read, ex_rd, ex_branch_taken, mem_busy,
    output pc_enable, if_id_enable, if_id_flush,
    output id_ex_enable, id_ex_bubble, ex_mem_enable,
    output timeout_err, state_o
  );

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_mem_read, ex_rd, ex_branch_taken, mem_busy,
    input  pc_enable, if_id_enable, if_id_flush,
    input  id_ex_enable, id_ex_bubble, ex_mem_enable,
    input  timeout_err, state_o
  );
endinterface

// File: rtl/hazard_lu_cmp.sv
// rtl/hazard_lu_cmp.sv - combinational load-use dependency comparator
module hazard_lu_cmp
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  output logic                  lu
);

  logic rd_nonzero;
  logic hit_rs1;
  logic hit_rs2;

  // x0 is hardwired, so a load targeting it never creates a dependency
  assign rd_nonzero = (ex_rd != REG_ADDR_W'(REG_ZERO));
  assign hit_rs1    = id_use_rs1 & (id_rs1 == ex_rd);
  assign hit_rs2    = id_use_rs2 & (id_rs2 == ex_rd);
  assign lu         = ex_mem_read & rd_nonzero & (hit_rs1 | hit_rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/freeze controller for the 5-stage RV32I pipeline
// Optional HAZARD_PERF_CNT_EN adds perf_clr and saturating lu/freeze/flush counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REDIRECT_CYCLES = 1,
  parameter int TIMEOUT         = 255,
  parameter int REG_ADDR_W      = REG_ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef HAZARD_PERF_CNT_EN
  input  logic        perf_clr,
  output logic [31:0] perf_lu,
  output logic [31:0] perf_mem,
  output logic [31:0] perf_flush,
`endif
  hazard_ctrl_if.slave hz
);

  localparam int RC_W = (REDIRECT_CYCLES > 1) ? $clog2(REDIRECT_CYCLES + 1) : 1;

  hz_state_e       state_q, state_d;
  logic [RC_W-1:0] redir_cnt_q, redir_cnt_d;
  logic [7:0]      wait_cnt_q, wait_cnt_d;
  logic            timeout_err_q, timeout_err_d;

  hz_ctrl_t ctrl;
  hz_ctrl_t ctrl_o;
  logic     lu;
  logic     run_rules;
  logic     mem_freeze;
  logic     lu_stall;

  hazard_lu_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_lu_cmp (
    .ex_mem_read (hz.ex_mem_read),
    .ex_rd       (hz.ex_rd),
    .id_rs1      (hz.id_rs1),
    .id_rs2      (hz.id_rs2),
    .id_use_rs1  (hz.id_use_rs1),
    .id_use_rs2  (hz.id_use_rs2),
    .lu          (lu)
  );

  always_comb begin
    ctrl          = CTRL_FREEZE;
    state_d       = state_q;
    redir_cnt_d   = redir_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    run_rules     = 1'b0;
    mem_freeze    = 1'b0;
    lu_stall      = 1'b0;

    case (state_q)
      ST_RUN: run_rules = 1'b1;
      ST_MEM_WAIT: begin
        if (hz.mem_busy) begin
          mem_freeze = 1'b1;
          wait_cnt_d = sat_inc8(wait_cnt_q);
        end else begin
          wait_cnt_d = 8'd0;
          run_rules  = 1'b1;
        end
      end
      ST_REDIRECT: begin
        if (hz.mem_busy) begin
          mem_freeze = 1'b1;
          wait_cnt_d = sat_inc8(wait_cnt_q);
        end else begin
          ctrl        = CTRL_REDIR;
          wait_cnt_d  = 8'd0;
          redir_cnt_d = redir_cnt_q - RC_W'(1);
          if (redir_cnt_q <= RC_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
      default: begin
        state_d     = ST_RUN;
        redir_cnt_d = '0;
        wait_cnt_d  = 8'd0;
      end
    endcase

    // MEM_WAIT falls through here on the cycle mem_busy drops, so there is no dead cycle
    if (run_rules) begin
      if (hz.mem_busy) begin
        mem_freeze = 1'b1;
        state_d    = ST_MEM_WAIT;
        wait_cnt_d = 8'd1;
      end else if (hz.ex_branch_taken) begin
        ctrl = CTRL_BRANCH;
        if (REDIRECT_CYCLES > 0) begin
          state_d     = ST_REDIRECT;
          redir_cnt_d = RC_W'(REDIRECT_CYCLES);
        end else begin
          state_d = ST_RUN;
        end
      end else if (lu) begin
        ctrl     = CTRL_LU;
        lu_stall = 1'b1;
        state_d  = ST_RUN;
      end else begin
        ctrl    = CTRL_NORMAL;
        state_d = ST_RUN;
      end
    end

    if (mem_freeze) begin
      ctrl = CTRL_FREEZE;
      if (int'(wait_cnt_d) == TIMEOUT) begin
        timeout_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      redir_cnt_q   <= '0;
      wait_cnt_q    <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      redir_cnt_q   <= redir_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign ctrl_o = rst_n ? ctrl : CTRL_RESET;

  assign hz.pc_enable     = ctrl_o.pc_en;
  assign hz.if_id_enable  = ctrl_o.if_id_en;
  assign hz.if_id_flush   = ctrl_o.if_id_flush;
  assign hz.id_ex_enable  = ctrl_o.id_ex_en;
  assign hz.id_ex_bubble  = ctrl_o.id_ex_bubble;
  assign hz.ex_mem_enable = ctrl_o.ex_mem_en;
  assign hz.timeout_err   = timeout_err_q;
  assign hz.state_o       = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_lu_d;
  logic [31:0] perf_mem_q, perf_mem_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic        frozen;

  assign frozen = (ctrl == CTRL_FREEZE);

  always_comb begin
    perf_lu_d    = perf_lu_q;
    perf_mem_d   = perf_mem_q;
    perf_flush_d = perf_flush_q;
    if (perf_clr) begin
      perf_lu_d    = 32'd0;
      perf_mem_d   = 32'd0;
      perf_flush_d = 32'd0;
    end else begin
      if (lu_stall)         perf_lu_d    = sat_inc32(perf_lu_q);
      if (frozen)           perf_mem_d   = sat_inc32(perf_mem_q);
      if (ctrl.if_id_flush) perf_flush_d = sat_inc32(perf_flush_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_q    <= 32'd0;
      perf_mem_q   <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_lu_q    <= perf_lu_d;
      perf_mem_q   <= perf_mem_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_lu    = perf_lu_q;
  assign perf_mem   = perf_mem_q;
  assign perf_flush = perf_flush_q;
`else
  logic unused_lu_stall;
  assign unused_lu_stall = lu_stall;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int RC = 2;
  localparam int TO = 255;
  localparam int AW = 5;

  localparam logic [5:0] C_NORM = 6'b110101;
  localparam logic [5:0] C_FRZ  = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b000111;
  localparam logic [5:0] C_BR   = 6'b111111;
  localparam logic [5:0] C_RDR  = 6'b111101;
  localparam logic [5:0] C_RST  = 6'b001010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_ADDR_W(AW)) hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic        perf_clr = 1'b0;
  logic [31:0] perf_lu;
  logic [31:0] perf_mem;
  logic [31:0] perf_flush;
`endif

  hazard_ctrl #(
    .REDIRECT_CYCLES (RC),
    .TIMEOUT         (TO),
    .REG_ADDR_W      (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef HAZARD_PERF_CNT_EN
    .perf_clr   (perf_clr),
    .perf_lu    (perf_lu),
    .perf_mem   (perf_mem),
    .perf_flush (perf_flush),
`endif
    .hz         (hz)
  );

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] e(input logic [1:0] st, input logic te, input logic [5:0] c);
    return {st, te, c};
  endfunction

  function automatic logic [8:0] obs();
    return {hz.state_o, hz.timeout_err, hz.pc_enable, hz.if_id_enable, hz.if_id_flush,
            hz.id_ex_enable, hz.id_ex_bubble, hz.ex_mem_enable};
  endfunction

  // lu_sel: 0 none, 1 rs2 hit, 2 rs1 hit, 3 rd=x0, 4 match without use flags
  task automatic apply_in(input logic br, input logic busy, input int lu_sel);
    hz.ex_branch_taken = br;
    hz.mem_busy        = busy;
    hz.ex_mem_read = 1'b0; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd1; hz.id_rs2 = 5'd2;
    hz.id_use_rs1  = 1'b0; hz.id_use_rs2 = 1'b0;
    case (lu_sel)
      1: begin hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd5; hz.id_rs2 = 5'd5; hz.id_use_rs2 = 1'b1;
               hz.id_rs1 = 5'd3; hz.id_use_rs1 = 1'b1; end
      2: begin hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd7; hz.id_rs1 = 5'd7; hz.id_use_rs1 = 1'b1; end
      3: begin hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd0; hz.id_rs1 = 5'd0; hz.id_rs2 = 5'd0;
               hz.id_use_rs1 = 1'b1; hz.id_use_rs2 = 1'b1; end
      4: begin hz.ex_mem_read = 1'b1; hz.ex_rd = 5'd9; hz.id_rs1 = 5'd9; hz.id_rs2 = 5'd9; end
      default: ;
    endcase
  endtask

  task automatic sample();
    exp_t x;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      x = sb.pop_front();
      check_eq(x.tag, 32'(obs()), 32'(x.exp));
    end
  endtask

  task automatic step(input string tag, input logic br, input logic busy, input int lu_sel,
                      input logic [8:0] exp);
    @(posedge clk);
    #1;
    apply_in(br, busy, lu_sel);
    sb.push_back('{tag, exp});
    @(negedge clk);
    sample();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    apply_in(1'b0, 1'b0, 0);
    #2;
    sb.push_back('{"rst_hold0", e(2'd0, 1'b0, C_RST)});
    sample();
    @(posedge clk);
    @(negedge clk);
    sb.push_back('{"rst_hold1", e(2'd0, 1'b0, C_RST)});
    sample();
    rst_n = 1'b1;

    step("idle",      1'b0, 1'b0, 0, e(2'd0, 1'b0, C_NORM));
    step("lu_rs2",    1'b0, 1'b0, 1, e(2'd0, 1'b0, C_LU));
    step("lu_after",  1'b0, 1'b0, 0, e(2'd0, 1'b0, C_NORM));
    step("lu_rs1",    1'b0, 1'b0, 2, e(2'd0, 1'b0, C_LU));
    step("rd_zero",   1'b0, 1'b0, 3, e(2'd0, 1'b0, C_NORM));
    step("no_use",    1'b0, 1'b0, 4, e(2'd0, 1'b0, C_NORM));

    step("br_lu",     1'b1, 1'b0, 1, e(2'd0, 1'b0, C_BR));
    step("redir1",    1'b0, 1'b0, 1, e(2'd2, 1'b0, C_RDR));
    step("redir2_br", 1'b1, 1'b0, 0, e(2'd2, 1'b0, C_RDR));
    step("redir_end", 1'b0, 1'b0, 0, e(2'd0, 1'b0, C_NORM));

    step("br2",       1'b1, 1'b0, 0, e(2'd0, 1'b0, C_BR));
    step("br2_rdr1",  1'b0, 1'b0, 0, e(2'd2, 1'b0, C_RDR));
    for (int i = 0; i < 4; i++)
      step($sformatf("rdr_frz%0d", i), 1'b0, 1'b1, 0, e(2'd2, 1'b0, C_FRZ));
    step("br2_rdr2",  1'b0, 1'b0, 0, e(2'd2, 1'b0, C_RDR));
    step("br2_end",   1'b0, 1'b0, 0, e(2'd0, 1'b0, C_NORM));

    step("busy_br",   1'b1, 1'b1, 0, e(2'd0, 1'b0, C_FRZ));
    step("wait_br",   1'b1, 1'b0, 0, e(2'd1, 1'b0, C_BR));
    step("wb_rdr1",   1'b0, 1'b0, 0, e(2'd2, 1'b0, C_RDR));
    step("wb_rdr2",   1'b0, 1'b0, 0, e(2'd2, 1'b0, C_RDR));
    step("wb_end",    1'b0, 1'b0, 0, e(2'd0, 1'b0, C_NORM));

    for (int k = 1; k <= 300; k++)
      step($sformatf("busy%0d", k), 1'b0, 1'b1, 0,
           e((k == 1) ? 2'd0 : 2'd1, (k >= 256), C_FRZ));
    step("fall_lu",   1'b0, 1'b0, 1, e(2'd1, 1'b1, C_LU));
    step("sticky",    1'b0, 1'b0, 0, e(2'd0, 1'b1, C_NORM));

    step("rb1",       1'b0, 1'b1, 0, e(2'd0, 1'b1, C_FRZ));
    step("rb2",       1'b0, 1'b1, 0, e(2'd1, 1'b1, C_FRZ));
    step("rb3",       1'b0, 1'b1, 0, e(2'd1, 1'b1, C_FRZ));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    sb.push_back('{"async_rst", e(2'd0, 1'b0, C_RST)});
    sample();
    @(negedge clk);
    sb.push_back('{"rst_low", e(2'd0, 1'b0, C_RST)});
    sample();
    apply_in(1'b0, 1'b0, 0);
    rst_n = 1'b1;
    step("post_rst",  1'b0, 1'b0, 0, e(2'd0, 1'b0, C_NORM));
    step("post_lu",   1'b0, 1'b0, 2, e(2'd0, 1'b0, C_LU));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
